// File: rtl/scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types, constants and helpers for the multiplexed
//                digit scanner (scan_ctrl and its slot timer).
//  Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

   // Scanner FSM: dark/idle, blanked slot lead-in, digit driven.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // Width of the digit select bus (feeds a 4:16 decoder).
   localparam int SEL_W = 4;

   // Largest supported digit count and the matching word width.
   localparam int MAX_DIGITS = 16;
   localparam int WORD_MAX_W = 4 * MAX_DIGITS;

   // Default parameter values for the scanner.
   localparam int DEF_NUM_DIGITS = 8;
   localparam int DEF_TICK_DIV   = 50000;
   localparam int DEF_GAP        = 4;

   // True when digit idx must be suppressed as a leading zero: blanking is
   // enabled, idx is not the least significant digit, and every digit from
   // idx upward is zero. The word is zero-extended by the caller, so digits
   // beyond the configured count read as zero and do not disturb the result.
   function automatic logic lead_zero_blanked(
      input logic [WORD_MAX_W-1:0] word,
      input logic [SEL_W-1:0]      idx,
      input logic                  enable
   );
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if ((i >= int'(idx)) && (word[4*i +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
      end
      return enable && (idx != '0) && upper_zero;
   endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_ctrl_if
//  Description : Valid/ready update channel carrying a new digit word into
//                the scanner's one-deep pending buffer.
//  Revision    : 1.0  initial release
// ============================================================================
interface scan_ctrl_if
   import scan_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS
);

   logic                    updValid;  // new digit word offered
   logic [4*NUM_DIGITS-1:0] updData;   // digit i in bits [4i+3:4i]
   logic                    updReady;  // pending buffer empty

   // Producer of digit words.
   modport master (
      output updValid,
      output updData,
      input  updReady
   );

   // Scanner side.
   modport slave (
      input  updValid,
      input  updData,
      output updReady
   );

endinterface : scan_ctrl_if
`default_nettype wire

// File: rtl/scan_ctrl_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : slot_timer
//  Description : Per-digit slot counter. Counts 0..TICK_DIV-1 while run is
//                high and flags the end of the blanked lead-in and the end
//                of the slot. Held at zero whenever run is low.
//  Revision    : 1.0  initial release
// ============================================================================
module slot_timer
   import scan_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,  // cycles per slot, >= GAP+2
   parameter int GAP      = DEF_GAP        // blanked lead-in cycles, >= 1
) (
   input  logic clk,
   input  logic resetL,
   input  logic run,
   output logic gapDone,
   output logic slotEnd
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: wrap at the slot end, clear whenever scanning is stopped.
   always_comb begin
      count_d = '0;
      if (run) begin
         count_d = (count_q == SLOT_LAST) ? '0 : count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Last lead-in cycle and last cycle of the slot.
   assign gapDone = run && (count_q == GAP_LAST);
   assign slotEnd = run && (count_q == SLOT_LAST);

endmodule : slot_timer
`default_nettype wire

// File: rtl/scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_ctrl
//  Description : Multiplexed hex-digit display scanner. Walks the digit index
//                once per slot, blanks the start of every slot against
//                ghosting, suppresses leading zeros on request and takes new
//                digit words through a one-deep buffer that is committed to
//                the displayed word only at frame boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_ctrl
   import scan_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,  // digits per frame, 2..16
   parameter int TICK_DIV   = DEF_TICK_DIV,    // cycles per slot, >= GAP+2
   parameter int GAP        = DEF_GAP          // blanked lead-in cycles, >= 1
) (
   input  logic             clk,
   input  logic             resetL,
   input  logic             scanEnable,
   input  logic             blankLeadZero,
   scan_ctrl_if.slave       upd,
   output logic [SEL_W-1:0] digitSel,
   output logic             decEnable,
   output logic [3:0]       hexOut,
   output logic             frameStart
);

   localparam int              DATA_W   = 4 * NUM_DIGITS;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   scan_state_t       state_q,     state_d;
   logic [SEL_W-1:0]  index_q,     index_d;
   logic              fs_q,        fs_d;         // frameStart output flop
   logic [DATA_W-1:0] active_q,    active_d;     // word being displayed
   logic [DATA_W-1:0] pend_q,      pend_d;       // buffered next word
   logic              upd_ready_q, upd_ready_d;  // high = buffer empty
   logic [SEL_W-1:0]  sel_q,       sel_d;
   logic              dec_en_q,    dec_en_d;
   logic [3:0]        hex_q,       hex_d;

   logic w_run;
   logic w_gap_done;
   logic w_slot_end;

   // The slot counter only advances once the FSM has left IDLE, so the first
   // slot after enabling starts from count 0 and a disable clears it at once.
   assign w_run = (state_q != scan_pkg::IDLE) && scanEnable;

   slot_timer #(
      .TICK_DIV (TICK_DIV),
      .GAP      (GAP)
   ) u_slot_timer (
      .clk     (clk),
      .resetL  (resetL),
      .run     (w_run),
      .gapDone (w_gap_done),
      .slotEnd (w_slot_end)
   );

   // Scan sequencing: next state, next digit index and the frame pulse.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      fs_d    = 1'b0;
      if (!scanEnable) begin
         state_d = scan_pkg::IDLE;
         index_d = '0;
      end else begin
         case (state_q)
            scan_pkg::IDLE: begin
               state_d = scan_pkg::GAP;
               index_d = '0;
               fs_d    = 1'b1;
            end
            scan_pkg::GAP: begin
               if (w_gap_done) begin
                  state_d = scan_pkg::DRIVE;
               end
            end
            scan_pkg::DRIVE: begin
               if (w_slot_end) begin
                  state_d = scan_pkg::GAP;
                  if (index_q == LAST_IDX) begin
                     index_d = '0;
                     fs_d    = 1'b1;
                  end else begin
                     index_d = index_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = scan_pkg::IDLE;
               index_d = '0;
            end
         endcase
      end
   end

   // Word buffering. The commit to the displayed word happens in the cycle
   // the frame pulse is visible, so a word accepted in that same cycle
   // lands in the (then empty) buffer and waits for the following frame.
   always_comb begin
      active_d    = active_q;
      pend_d      = pend_q;
      upd_ready_d = upd_ready_q;
      if (fs_q && !upd_ready_q) begin
         active_d    = pend_q;
         upd_ready_d = 1'b1;
      end
      if (upd.updValid && upd_ready_q) begin
         pend_d      = upd.updData;
         upd_ready_d = 1'b0;
      end
   end

   // Output decode from the next-cycle state so every output is a flop that
   // changes on the same edge as the state it reflects.
   always_comb begin
      sel_d    = '0;
      dec_en_d = 1'b0;
      hex_d    = 4'h0;
      if (state_d != scan_pkg::IDLE) begin
         sel_d = index_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_d == SEL_W'(i)) begin
               hex_d = active_d[4*i +: 4];
            end
         end
         dec_en_d = (state_d == scan_pkg::DRIVE) &&
                    !lead_zero_blanked(WORD_MAX_W'(active_d), index_d, blankLeadZero);
      end
   end

   // State, buffer and output registers.
   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         state_q     <= scan_pkg::IDLE;
         index_q     <= '0;
         fs_q        <= 1'b0;
         active_q    <= '0;
         pend_q      <= '0;
         upd_ready_q <= 1'b1;
         sel_q       <= '0;
         dec_en_q    <= 1'b0;
         hex_q       <= 4'h0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         fs_q        <= fs_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         upd_ready_q <= upd_ready_d;
         sel_q       <= sel_d;
         dec_en_q    <= dec_en_d;
         hex_q       <= hex_d;
      end
   end

   assign digitSel     = sel_q;
   assign decEnable    = dec_en_q;
   assign hexOut       = hex_q;
   assign frameStart   = fs_q;
   assign upd.updReady = upd_ready_q;

endmodule : scan_ctrl
`default_nettype wire

// File: tb/tb_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_ctrl
//  Description : Self-checking bench for scan_ctrl (4 digits, 8-cycle slots,
//                2-cycle lead-in). A frame-position model predicts all
//                outputs every cycle; directed literal checks pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_ctrl;

   localparam int NUM_DIGITS = 4;
   localparam int TICK_DIV   = 8;
   localparam int GAP_CYC    = 2;
   localparam int FRAME      = NUM_DIGITS * TICK_DIV;

   logic       clk           = 1'b0;
   logic       resetL        = 1'b0;
   logic       scanEnable    = 1'b0;
   logic       blankLeadZero = 1'b0;
   logic [3:0] digitSel;
   logic       decEnable;
   logic [3:0] hexOut;
   logic       frameStart;

   int total = 0;
   int bad   = 0;

   scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) upd_if ();

   scan_ctrl #(
      .NUM_DIGITS (NUM_DIGITS),
      .TICK_DIV   (TICK_DIV),
      .GAP        (GAP_CYC)
   ) dut (
      .clk           (clk),
      .resetL        (resetL),
      .scanEnable    (scanEnable),
      .blankLeadZero (blankLeadZero),
      .upd           (upd_if),
      .digitSel      (digitSel),
      .decEnable     (decEnable),
      .hexOut        (hexOut),
      .frameStart    (frameStart)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Model: position within the frame plus the two word registers.
   // ---------------------------------------------------------------------
   bit          m_on     = 1'b0;
   int          m_cyc    = 0;
   bit          m_fs     = 1'b0;
   logic [15:0] m_active = 16'h0;
   logic [15:0] m_pend   = 16'h0;
   bit          m_full   = 1'b0;
   bit          m_blz    = 1'b0;
   bit          m_acc;
   bit          m_cpy;

   always @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         m_on = 0; m_cyc = 0; m_fs = 0; m_active = 16'h0;
         m_pend = 16'h0; m_full = 0; m_blz = 0;
      end else begin
         m_acc = upd_if.updValid && !m_full;
         m_cpy = m_fs && m_full;
         if (m_cpy) begin m_active = m_pend; m_full = 0; end
         if (m_acc) begin m_pend = upd_if.updData; m_full = 1; end
         if (!scanEnable) begin
            m_on = 0; m_cyc = 0; m_fs = 0;
         end else if (!m_on) begin
            m_on = 1; m_cyc = 0; m_fs = 1;
         end else begin
            m_cyc = (m_cyc + 1) % FRAME;
            m_fs  = (m_cyc == 0);
         end
         m_blz = blankLeadZero;
      end
   end

   bit started = 1'b0;

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int         slot;
      int         off;
      logic [3:0] e_sel;
      logic [3:0] e_hex;
      logic       e_dec;
      logic       e_fs;
      logic       e_rdy;
      if (started) begin
         slot  = m_cyc / TICK_DIV;
         off   = m_cyc % TICK_DIV;
         e_sel = m_on ? 4'(slot) : 4'h0;
         e_hex = m_on ? m_active[4*slot +: 4] : 4'h0;
         e_dec = m_on && (off >= GAP_CYC) &&
                 !(m_blz && (slot > 0) && ((m_active >> (4*slot)) == 16'h0));
         e_fs  = m_fs;
         e_rdy = !m_full;
         total++;
         if ({digitSel, decEnable, hexOut, frameStart, upd_if.updReady} !==
             {e_sel, e_dec, e_hex, e_fs, e_rdy}) begin
            bad++;
            $display("FAIL model_cycle t=%0t got sel=%0h dec=%0b hex=%0h fs=%0b rdy=%0b expected sel=%0h dec=%0b hex=%0h fs=%0b rdy=%0b",
                     $time, digitSel, decEnable, hexOut, frameStart, upd_if.updReady,
                     e_sel, e_dec, e_hex, e_fs, e_rdy);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed helpers
   // ---------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance at least one cycle, then until the frame pulse (bounded).
   task automatic wait_fs();
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while ((frameStart !== 1'b1) && (n < 80));
      chk("wait_frame_start", {31'b0, frameStart}, 32'd1);
   endtask

   int         on_cnt [NUM_DIGITS];
   logic [3:0] hex_at [NUM_DIGITS];
   int         fs_cnt;
   int         sel_bad;

   // Observe one whole frame starting at its first cycle.
   task automatic run_frame();
      for (int s = 0; s < NUM_DIGITS; s++) begin
         on_cnt[s] = 0;
         hex_at[s] = 4'h0;
      end
      fs_cnt  = 0;
      sel_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
         int s;
         s = i / TICK_DIV;
         on_cnt[s] += int'(decEnable);
         fs_cnt    += int'(frameStart);
         if (digitSel !== 4'(s)) sel_bad++;
         if ((i % TICK_DIV) == TICK_DIV - 1) hex_at[s] = hexOut;
         step(1);
      end
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int n;
      upd_if.updValid = 1'b0;
      upd_if.updData  = 16'h0;

      // Reset values while held in reset.
      step(2);
      started = 1'b1;
      chk("rst_decEnable",  {31'b0, decEnable},       32'd0);
      chk("rst_digitSel",   {28'b0, digitSel},        32'd0);
      chk("rst_hexOut",     {28'b0, hexOut},          32'd0);
      chk("rst_frameStart", {31'b0, frameStart},      32'd0);
      chk("rst_updReady",   {31'b0, upd_if.updReady}, 32'd1);
      resetL = 1'b1;
      step(2);

      // Basic scan with an all-zero word.
      scanEnable = 1'b1;
      step(1);
      chk("en_frameStart", {31'b0, frameStart}, 32'd1);
      chk("en_digitSel",   {28'b0, digitSel},   32'd0);
      chk("en_decEnable",  {31'b0, decEnable},  32'd0);
      run_frame();
      chk("f1_fs_count", fs_cnt, 32'd1);
      chk("f1_sel_seq",  sel_bad, 32'd0);
      for (int s = 0; s < NUM_DIGITS; s++) chk("f1_slot_on", on_cnt[s], 32'd6);
      chk("f1_wrap_fs",  {31'b0, frameStart}, 32'd1);
      chk("f1_wrap_sel", {28'b0, digitSel},   32'd0);

      // Mid-frame update waits for the next frame.
      step(10);
      upd_if.updValid = 1'b1;
      upd_if.updData  = 16'h1234;
      step(1);
      upd_if.updValid = 1'b0;
      chk("u1_ready_low", {31'b0, upd_if.updReady}, 32'd0);
      chk("u1_hex_old",   {28'b0, hexOut},          32'd0);
      wait_fs();
      chk("u1_ready_at_fs", {31'b0, upd_if.updReady}, 32'd0);
      chk("u1_hex_at_fs",   {28'b0, hexOut},          32'd0);
      step(1);
      chk("u1_ready_rise", {31'b0, upd_if.updReady}, 32'd1);
      chk("u1_hex_d0",     {28'b0, hexOut},          32'h4);
      step(8);
      chk("u1_hex_d1",     {28'b0, hexOut},          32'h3);

      // Leading-zero blanking with 0x0050.
      blankLeadZero   = 1'b1;
      upd_if.updValid = 1'b1;
      upd_if.updData  = 16'h0050;
      step(1);
      upd_if.updValid = 1'b0;
      wait_fs();
      run_frame();
      chk("b1_slot0_on", on_cnt[0], 32'd6);
      chk("b1_slot1_on", on_cnt[1], 32'd6);
      chk("b1_slot2_on", on_cnt[2], 32'd0);
      chk("b1_slot3_on", on_cnt[3], 32'd0);
      chk("b1_hex_d0",   {28'b0, hex_at[0]}, 32'h0);
      chk("b1_hex_d1",   {28'b0, hex_at[1]}, 32'h5);

      // Accept in the frame-pulse cycle goes to the buffer, not the display.
      upd_if.updValid = 1'b1;
      upd_if.updData  = 16'h0000;
      step(1);
      upd_if.updValid = 1'b0;
      chk("b2_ready_low", {31'b0, upd_if.updReady}, 32'd0);
      step(14);
      chk("b2_old_dec_d1", {31'b0, decEnable}, 32'd1);
      chk("b2_old_hex_d1", {28'b0, hexOut},    32'h5);
      wait_fs();
      run_frame();
      chk("b2_slot0_on", on_cnt[0], 32'd6);
      chk("b2_slot1_on", on_cnt[1], 32'd0);
      chk("b2_slot2_on", on_cnt[2], 32'd0);
      chk("b2_slot3_on", on_cnt[3], 32'd0);

      // Second word held off while the buffer is full.
      upd_if.updValid = 1'b1;
      upd_if.updData  = 16'hAAAA;
      step(1);
      upd_if.updData  = 16'hBBBB;
      n = 0;
      while ((upd_if.updReady !== 1'b1) && (n < 60)) begin
         step(1);
         n++;
      end
      chk("h1_hold_cycles", n, 32'd32);
      chk("h1_hex_A",       {28'b0, hexOut}, 32'hA);
      step(1);
      upd_if.updValid = 1'b0;
      chk("h1_B_taken",     {31'b0, upd_if.updReady}, 32'd0);
      step(18);
      chk("h1_hex_A_d2",    {28'b0, hexOut}, 32'hA);
      wait_fs();
      step(1);
      chk("h1_hex_B",       {28'b0, hexOut}, 32'hB);
      chk("h1_ready_back",  {31'b0, upd_if.updReady}, 32'd1);

      // Disable in slot 2 DRIVE, then restart.
      step(19);
      chk("d1_pre_dec", {31'b0, decEnable}, 32'd1);
      chk("d1_pre_sel", {28'b0, digitSel},  32'd2);
      scanEnable = 1'b0;
      step(1);
      chk("d1_dec_off", {31'b0, decEnable},  32'd0);
      chk("d1_sel_0",   {28'b0, digitSel},   32'd0);
      chk("d1_hex_0",   {28'b0, hexOut},     32'd0);
      chk("d1_fs_0",    {31'b0, frameStart}, 32'd0);
      step(3);
      scanEnable = 1'b1;
      step(1);
      chk("d1_restart_fs",  {31'b0, frameStart}, 32'd1);
      chk("d1_restart_sel", {28'b0, digitSel},   32'd0);
      step(8);
      chk("d1_kept_sel", {28'b0, digitSel}, 32'd1);
      chk("d1_kept_hex", {28'b0, hexOut},   32'hB);

      // Asynchronous reset mid-DRIVE with a word pending.
      upd_if.updValid = 1'b1;
      upd_if.updData  = 16'hCCCC;
      step(1);
      upd_if.updValid = 1'b0;
      chk("r1_pending", {31'b0, upd_if.updReady}, 32'd0);
      step(1);
      chk("r1_in_drive", {31'b0, decEnable}, 32'd1);
      #2;
      resetL = 1'b0;
      #1;
      chk("r1_dec",   {31'b0, decEnable},       32'd0);
      chk("r1_sel",   {28'b0, digitSel},        32'd0);
      chk("r1_hex",   {28'b0, hexOut},          32'd0);
      chk("r1_fs",    {31'b0, frameStart},      32'd0);
      chk("r1_ready", {31'b0, upd_if.updReady}, 32'd1);
      step(1);
      chk("r1_held_fs", {31'b0, frameStart}, 32'd0);
      resetL = 1'b1;
      step(1);
      chk("r1_first_edge_fs", {31'b0, frameStart}, 32'd1);
      step(8);
      chk("r1_sel_d1", {28'b0, digitSel}, 32'd1);
      chk("r1_hex_d1", {28'b0, hexOut},   32'h0);
      wait_fs();
      step(1);
      chk("r1_discarded_hex", {28'b0, hexOut},          32'h0);
      chk("r1_ready_after",   {31'b0, upd_if.updReady}, 32'd1);

      step(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if the run ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule : tb_scan_ctrl
`default_nettype wire
